// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO receive-side frame controller.
package sipo_pkg;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_e;

   // Bits needed to count 0..max_val, never narrower than one bit.
   function automatic int ctr_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in/parallel-out shifter. Bits enter at the MSB and move
// toward the LSB, so after WIDTH shifts the first bit sits in q[0].
module sipo_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             restart,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sreg_q;

   // Restart wins over shift: it begins a new word with din as its only bit.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (reset) begin
         sreg_q <= '0;
      end else if (restart) begin
         sreg_q <= {din, {(WIDTH-1){1'b0}}};
      end else if (shift_en) begin
         sreg_q <= {din, sreg_q[WIDTH-1:1]};
      end
   end

   assign q = sreg_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Receive-side controller: frames serial bits into WIDTH-bit words, detects
// gap timeouts and mid-frame resyncs, and hands each completed word to the
// consumer through a single output register with a valid/ready handshake.
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             sof,
   output logic [WIDTH-1:0] pdata,
   output logic             pvalid,
   input  logic             pready,
   output logic             busy,
   output logic             overrun,
   output logic             timeout_err,
   output logic             resync_err
);

   localparam int CNT_W = ctr_width(WIDTH);
   localparam int GAP_W = ctr_width(TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [WIDTH-1:0] pdata_q, pdata_d;
   logic             pvalid_q, pvalid_d;
   logic             overrun_q, overrun_d;
   logic             timeout_q, timeout_d;
   logic             resync_q, resync_d;

   logic             sr_shift, sr_restart, complete;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] word;
   logic             unused_sr_lsb;

   sipo_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift_reg (
      .clk      (clk),
      .reset    (reset),
      .shift_en (sr_shift),
      .restart  (sr_restart),
      .din      (sin),
      .q        (sr_q)
   );

   // The completed word includes the bit arriving this cycle; the oldest
   // shifter bit falls off the end and is not part of it.
   assign word          = {sin, sr_q[WIDTH-1:1]};
   assign unused_sr_lsb = sr_q[0];

   // Next-state logic: frame sequencing, gap timer, output register and handshake.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      pdata_d    = pdata_q;
      pvalid_d   = pvalid_q;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
      resync_d   = 1'b0;
      sr_shift   = 1'b0;
      sr_restart = 1'b0;
      complete   = 1'b0;

      if (pvalid_q && pready) begin
         pvalid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (sin_en && sof) begin
               sr_restart = 1'b1;
               cnt_d      = CNT_W'(1);
               gap_d      = '0;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (sin_en && sof) begin
               resync_d   = 1'b1;
               sr_restart = 1'b1;
               cnt_d      = CNT_W'(1);
               gap_d      = '0;
            end else if (sin_en) begin
               sr_shift = 1'b1;
               gap_d    = '0;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               if (gap_q != '1) begin
                  gap_d = gap_q + GAP_W'(1);
               end
               if ((TIMEOUT != 0) && (gap_d == GAP_W'(TIMEOUT))) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A word is delivered only if the output slot is free or being drained
      // this same cycle; otherwise it is dropped and the held word survives.
      if (complete) begin
         if (!pvalid_q || pready) begin
            pdata_d  = word;
            pvalid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State, counters, output register and registered error pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         gap_q     <= '0;
         pdata_q   <= '0;
         pvalid_q  <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         resync_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         pdata_q   <= pdata_d;
         pvalid_q  <= pvalid_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         resync_q  <= resync_d;
      end
   end

   assign pdata       = pdata_q;
   assign pvalid      = pvalid_q;
   assign busy        = (state_q == S_SHIFT);
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;
   assign resync_err  = resync_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_sipo_frame_ctrl;

   localparam int W  = 4;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         sin, sin_en, sof, pready;
   logic [W-1:0] pdata;
   logic         pvalid, busy, overrun, timeout_err, resync_err;

   int n_vectors   = 0;
   int n_miscomp   = 0;

   // Reference model state: the bits of the frame in progress, the idle run
   // length inside the frame, and the consumer-facing word.
   bit       frame_bits[$];
   bit       in_frame;
   int       idle_run;
   bit [W-1:0] m_pdata;
   bit       m_pvalid;
   bit       m_ovr, m_tmo, m_rsy;

   sipo_frame_ctrl #(
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sin         (sin),
      .sin_en      (sin_en),
      .sof         (sof),
      .pdata       (pdata),
      .pvalid      (pvalid),
      .pready      (pready),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .resync_err  (resync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vectors++;
      if (obs !== expv) begin
         n_miscomp++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
      end
   endtask

   // Advances the model by one clock given the inputs present before the edge.
   task automatic model_step(input bit s, input bit en, input bit f, input bit rdy, input bit rst);
      bit       held;
      bit [W-1:0] w;
      m_ovr = 0;
      m_tmo = 0;
      m_rsy = 0;
      if (rst) begin
         frame_bits.delete();
         in_frame = 0;
         idle_run = 0;
         m_pdata  = '0;
         m_pvalid = 0;
         return;
      end
      held = m_pvalid;
      if (m_pvalid && rdy) m_pvalid = 0;
      if (en && f) begin
         if (in_frame) m_rsy = 1;
         frame_bits.delete();
         frame_bits.push_back(s);
         in_frame = 1;
         idle_run = 0;
      end else if (en && in_frame) begin
         frame_bits.push_back(s);
         idle_run = 0;
         if (frame_bits.size() == W) begin
            w = '0;
            for (int i = 0; i < W; i++) w = w | (W'(frame_bits[i]) << i);
            if (!held || rdy) begin
               m_pdata  = w;
               m_pvalid = 1;
            end else begin
               m_ovr = 1;
            end
            frame_bits.delete();
            in_frame = 0;
         end
      end else if (!en && in_frame) begin
         idle_run++;
         if (TO != 0 && idle_run >= TO) begin
            m_tmo = 1;
            frame_bits.delete();
            in_frame = 0;
         end
      end
   endtask

   // Drives one cycle of inputs, clocks, then compares every output to the model.
   task automatic apply(input bit s, input bit en, input bit f, input bit rdy, input bit rst);
      sin    = s;
      sin_en = en;
      sof    = f;
      pready = rdy;
      reset  = rst;
      @(posedge clk);
      model_step(s, en, f, rdy, rst);
      #1;
      check("pdata",       32'(pdata),       32'(m_pdata));
      check("pvalid",      32'(pvalid),      32'(m_pvalid));
      check("busy",        32'(busy),        32'(in_frame));
      check("overrun",     32'(overrun),     32'(m_ovr));
      check("timeout_err", 32'(timeout_err), 32'(m_tmo));
      check("resync_err",  32'(resync_err),  32'(m_rsy));
   endtask

   initial begin
      int  burst;
      bit  en, f, rdy, rst;

      sin = 0; sin_en = 0; sof = 0; pready = 0; reset = 1;
      in_frame = 0; idle_run = 0; m_pdata = '0; m_pvalid = 0;

      // Reset state.
      apply(0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 1);
      check("rst_pdata", 32'(pdata), 32'h0);
      check("rst_pvalid", 32'(pvalid), 32'h0);

      // 1: frame 1,0,1,1 with consumer stalled.
      apply(1, 1, 1, 0, 0);
      apply(0, 1, 0, 0, 0);
      apply(1, 1, 0, 0, 0);
      apply(1, 1, 0, 0, 0);
      check("t1_pdata", 32'(pdata), 32'hd);
      check("t1_pvalid", 32'(pvalid), 32'h1);
      check("t1_busy", 32'(busy), 32'h0);

      // 2: second frame while full -> overrun, then drain.
      apply(0, 1, 1, 0, 0);
      apply(0, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      apply(1, 1, 0, 0, 0);
      check("t2_overrun", 32'(overrun), 32'h1);
      check("t2_pdata", 32'(pdata), 32'hd);
      apply(0, 0, 0, 1, 0);
      check("t2_drain", 32'(pvalid), 32'h0);

      // 3: two bits then eight idle cycles -> timeout.
      apply(1, 1, 1, 0, 0);
      apply(1, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) apply(0, 0, 0, 0, 0);
      check("t3_no_early_tmo", 32'(timeout_err), 32'h0);
      apply(0, 0, 0, 0, 0);
      check("t3_tmo", 32'(timeout_err), 32'h1);
      check("t3_busy", 32'(busy), 32'h0);
      check("t3_pvalid", 32'(pvalid), 32'h0);

      // 4: resync mid-frame, new frame 0,1,1,0 delivered.
      apply(1, 1, 1, 0, 0);
      apply(0, 1, 0, 0, 0);
      apply(0, 1, 1, 0, 0);
      check("t4_resync", 32'(resync_err), 32'h1);
      apply(1, 1, 0, 0, 0);
      apply(1, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      check("t4_pdata", 32'(pdata), 32'h6);
      apply(0, 0, 0, 1, 0);

      // 5: reset mid-frame, then clean frame 1,1,1,0.
      apply(1, 1, 1, 0, 0);
      apply(1, 1, 0, 0, 0);
      apply(1, 1, 0, 0, 0);
      apply(0, 0, 0, 0, 1);
      check("t5_busy_after_rst", 32'(busy), 32'h0);
      apply(1, 1, 1, 0, 0);
      apply(1, 1, 0, 0, 0);
      apply(1, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      check("t5_pdata", 32'(pdata), 32'h7);

      // 6: completion coinciding with a handshake replaces the word, no overrun.
      apply(0, 1, 1, 0, 0);
      apply(1, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      apply(1, 1, 0, 1, 0);
      check("t6_overrun", 32'(overrun), 32'h0);
      check("t6_pvalid", 32'(pvalid), 32'h1);
      check("t6_pdata", 32'(pdata), 32'ha);

      // Random traffic with occasional long idle bursts to provoke timeouts.
      burst = 0;
      for (int c = 0; c < 4000; c++) begin
         if (burst > 0) begin
            en = 0;
            burst--;
         end else if ($urandom_range(39) == 0) begin
            en = 0;
            burst = $urandom_range(12, 5);
         end else begin
            en = ($urandom_range(3) != 0);
         end
         f   = en ? ($urandom_range(5) == 0) : $urandom_range(1) == 1;
         rdy = ($urandom_range(9) < 4);
         rst = ($urandom_range(299) == 0);
         apply(1'($urandom_range(1)), en, f, rdy, rst);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscomp);
      $finish;
   end

endmodule
